// File: rtl/washer_phase_timer.sv
// Per-phase countdown timer: loads a frequency-scaled phase duration on start,
// counts it down with pause/abort support and pulses done on completion.
//
//   state  | meaning
//   S_IDLE | no phase timing; start is accepted here
//   S_RUN  | counting down one tick per clock
//   S_HOLD | paused; remaining is frozen
module washer_phase_timer #(
    parameter int unsigned CNT_W       = 32,
    parameter logic [63:0] FILL_TICKS  = 64'd120000000,
    parameter logic [63:0] WASH_TICKS  = 64'd300000000,
    parameter logic [63:0] RINSE_TICKS = 64'd120000000,
    parameter logic [63:0] SPIN_TICKS  = 64'd60000000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [3:0]       i_clock_frequency,
    input  logic [2:0]       i_phase,
    input  logic             i_start,
    input  logic             i_pause,
    input  logic             i_abort,
    output logic             o_busy,
    output logic             o_paused,
    output logic             o_done,
    output logic             o_cfg_err,
    output logic [2:0]       o_active_phase,
    output logic [CNT_W-1:0] o_remaining
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HOLD
    } state_t;

    // Wide enough that any 64-bit base shifted by up to 3 cannot hide an overflow
    // for the counter widths this block is used with.
    localparam logic [63:0] MAX_CNT = (64'd1 << CNT_W) - 64'd1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_busy;
    logic             r_paused;
    logic             r_done;
    logic             r_cfg_err;
    logic [2:0]       r_active_phase;
    logic [CNT_W-1:0] r_remaining;

    logic             w_busy_nxt;
    logic             w_paused_nxt;
    logic             w_done_nxt;
    logic             w_cfg_err_nxt;
    logic [2:0]       w_phase_nxt;
    logic [CNT_W-1:0] w_remaining_nxt;

    logic [63:0]      w_base;
    logic             w_phase_ok;
    logic [1:0]       w_shift;
    logic             w_freq_ok;
    logic [63:0]      w_scaled;
    logic [CNT_W-1:0] w_load;

    always_comb begin
        w_base     = '0;
        w_phase_ok = 1'b1;
        case (i_phase)
            3'b001:  w_base = FILL_TICKS;
            3'b010:  w_base = WASH_TICKS;
            3'b011:  w_base = RINSE_TICKS;
            3'b100:  w_base = SPIN_TICKS;
            default: w_phase_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_shift   = 2'd0;
        w_freq_ok = 1'b1;
        case (i_clock_frequency)
            4'b0001: w_shift = 2'd0;
            4'b0010: w_shift = 2'd1;
            4'b0100: w_shift = 2'd2;
            4'b1000: w_shift = 2'd3;
            default: w_freq_ok = 1'b0;
        endcase
    end

    assign w_scaled = w_base << w_shift;
    assign w_load   = (w_scaled > MAX_CNT) ? '1 : w_scaled[CNT_W-1:0];

    always_comb begin
        w_state_nxt     = r_state;
        w_busy_nxt      = r_busy;
        w_paused_nxt    = r_paused;
        w_done_nxt      = 1'b0;
        w_cfg_err_nxt   = 1'b0;
        w_phase_nxt     = r_active_phase;
        w_remaining_nxt = r_remaining;

        if (i_abort) begin
            w_state_nxt     = S_IDLE;
            w_busy_nxt      = 1'b0;
            w_paused_nxt    = 1'b0;
            w_phase_nxt     = 3'b000;
            w_remaining_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (w_phase_ok && w_freq_ok) begin
                            w_remaining_nxt = w_load;
                            w_phase_nxt     = i_phase;
                            w_busy_nxt      = 1'b1;
                            w_paused_nxt    = i_pause;
                            w_state_nxt     = i_pause ? S_HOLD : S_RUN;
                        end else begin
                            w_cfg_err_nxt = 1'b1;
                        end
                    end
                end
                S_RUN, S_HOLD: begin
                    if (i_pause) begin
                        w_state_nxt  = S_HOLD;
                        w_paused_nxt = 1'b1;
                    end else if (r_remaining <= CNT_W'(1)) begin
                        // Also covers a zero-length phase, which finishes on the first edge.
                        w_state_nxt     = S_IDLE;
                        w_remaining_nxt = '0;
                        w_done_nxt      = 1'b1;
                        w_busy_nxt      = 1'b0;
                        w_paused_nxt    = 1'b0;
                        w_phase_nxt     = 3'b000;
                    end else begin
                        w_state_nxt     = S_RUN;
                        w_paused_nxt    = 1'b0;
                        w_remaining_nxt = r_remaining - CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt     = S_IDLE;
                    w_busy_nxt      = 1'b0;
                    w_paused_nxt    = 1'b0;
                    w_phase_nxt     = 3'b000;
                    w_remaining_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            r_busy         <= 1'b0;
            r_paused       <= 1'b0;
            r_done         <= 1'b0;
            r_cfg_err      <= 1'b0;
            r_active_phase <= 3'b000;
            r_remaining    <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_busy         <= w_busy_nxt;
            r_paused       <= w_paused_nxt;
            r_done         <= w_done_nxt;
            r_cfg_err      <= w_cfg_err_nxt;
            r_active_phase <= w_phase_nxt;
            r_remaining    <= w_remaining_nxt;
        end
    end

    assign o_busy         = r_busy;
    assign o_paused       = r_paused;
    assign o_done         = r_done;
    assign o_cfg_err      = r_cfg_err;
    assign o_active_phase = r_active_phase;
    assign o_remaining    = r_remaining;

endmodule
